// File: rtl/control_r_pkg.sv
// Shared definitions for the RX packet router: PID types, PID values,
// router FSM states and the beat payload carried by the output slots.
package control_r_pkg;

    // PID type field lives in data[1:0] of the first byte
    localparam logic [1:0] PID_SPECIAL = 2'b00;
    localparam logic [1:0] PID_TOKEN   = 2'b01;
    localparam logic [1:0] PID_HSK     = 2'b10;
    localparam logic [1:0] PID_DATA    = 2'b11;

    // Full 4-bit PID values as they appear in data[3:0]
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_PRE   = 4'hC;

    // Slot payload is {sop, eop, data}
    localparam int PAYLOAD_W = 10;

    // Router states: idle, forwarding to crc5 path, forwarding to link layer, discarding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROUTE_TO = 2'd1,
        ST_ROUTE_LR = 2'd2,
        ST_DROP     = 2'd3
    } state_e;

    // A PID byte is well formed when the high nibble is the complement of the low nibble
    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[3:0] == ~pid_byte[7:4];
    endfunction

endpackage

// File: rtl/control_r_out_slot.sv
// One-entry registered output slot. Loads a beat when told to, holds it until
// the consumer takes it, and can load and drain in the same cycle so a steady
// stream flows at one beat per clock.
module rx_out_slot
    import control_r_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 free,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 valid_q;
    logic                 valid_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PAYLOAD_W-1:0] payload_d;

    // Slot accepts a new beat when empty or when its current beat leaves this cycle
    always_comb begin
        free      = ~valid_q | out_ready;
        valid_d   = valid_q;
        payload_d = payload_q;
        if (load) begin
            valid_d   = 1'b1;
            payload_d = in_payload;
        end else if (valid_q && out_ready) begin
            valid_d   = 1'b0;
        end
    end

    // Slot registers; payload holds its value while empty or stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;

endmodule

// File: rtl/control_r.sv
// RX-side packet router: decodes the PID of each packet arriving from the PHY
// and steers token/handshake packets to the crc5 checker and data packets to
// the link layer, dropping malformed and special packets.
module control_r
    import control_r_pkg::*;
#(
    parameter logic CHECK_PID    = 1'b1,
    parameter logic DROP_SPECIAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_lp_sop,
    input  logic       rx_lp_eop,
    input  logic       rx_lp_valid,
    output logic       rx_lp_ready,
    input  logic [7:0] rx_lp_data,
    output logic       rx_to_sop,
    output logic       rx_to_eop,
    output logic       rx_to_valid,
    input  logic       rx_to_ready,
    output logic [7:0] rx_to_data,
    output logic       rx_lr_sop,
    output logic       rx_lr_eop,
    output logic       rx_lr_valid,
    input  logic       rx_lr_ready,
    output logic [7:0] rx_lr_data,
    output logic       rx_data_on,
    output logic [3:0] rx_pid,
    output logic       rx_pid_err,
    output logic       rx_frame_err
);

    state_e     state_q;
    state_e     state_d;
    state_e     sop_dest;
    state_e     sop_next;
    logic [3:0] pid_q;
    logic [3:0] pid_d;
    logic       pid_err_q;
    logic       pid_err_d;
    logic       frame_err_q;
    logic       frame_err_d;

    logic       to_free;
    logic       lr_free;
    logic       to_load;
    logic       lr_load;
    logic       beat_acc;
    logic       pid_good;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] to_payload;
    logic [PAYLOAD_W-1:0] lr_payload;

    assign beat_acc   = rx_lp_valid & rx_lp_ready;
    assign in_payload = {rx_lp_sop, rx_lp_eop, rx_lp_data};

    // Input ready depends only on state and slot occupancy, never on the byte itself
    always_comb begin
        rx_lp_ready = 1'b0;
        unique case (state_q)
            ST_IDLE:     rx_lp_ready = to_free & lr_free;
            ST_ROUTE_TO: rx_lp_ready = to_free;
            ST_ROUTE_LR: rx_lp_ready = lr_free;
            ST_DROP:     rx_lp_ready = 1'b1;
            default:     rx_lp_ready = 1'b0;
        endcase
    end

    // Decode the PID byte into the state the packet would be routed to
    always_comb begin
        pid_good = ~CHECK_PID | pid_ok(rx_lp_data);
        sop_dest = ST_DROP;
        if (pid_good) begin
            unique case (rx_lp_data[1:0])
                PID_TOKEN,
                PID_HSK:     sop_dest = ST_ROUTE_TO;
                PID_DATA:    sop_dest = ST_ROUTE_LR;
                PID_SPECIAL: sop_dest = DROP_SPECIAL ? ST_DROP : ST_ROUTE_TO;
                default:     sop_dest = ST_DROP;
            endcase
        end
    end

    // Next-state, slot loads and error pulses for each accepted beat
    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        pid_err_d   = 1'b0;
        frame_err_d = 1'b0;
        to_load     = 1'b0;
        lr_load     = 1'b0;
        sop_next    = sop_dest;
        if (beat_acc) begin
            if (rx_lp_sop) begin
                pid_d       = rx_lp_data[3:0];
                pid_err_d   = ~pid_good;
                frame_err_d = (state_q != ST_IDLE);
                if (sop_dest == ST_ROUTE_TO) begin
                    if (to_free) begin
                        to_load = 1'b1;
                    end else begin
                        sop_next = ST_DROP;
                    end
                end else if (sop_dest == ST_ROUTE_LR) begin
                    if (lr_free) begin
                        lr_load = 1'b1;
                    end else begin
                        sop_next = ST_DROP;
                    end
                end
                state_d = rx_lp_eop ? ST_IDLE : sop_next;
            end else begin
                unique case (state_q)
                    ST_IDLE:     frame_err_d = 1'b1;
                    ST_ROUTE_TO: to_load     = 1'b1;
                    ST_ROUTE_LR: lr_load     = 1'b1;
                    ST_DROP:     to_load     = 1'b0;
                    default:     to_load     = 1'b0;
                endcase
                if (rx_lp_eop) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // FSM state, latched PID and registered error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pid_q       <= 4'h0;
            pid_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            pid_err_q   <= pid_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    rx_out_slot u_to_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (to_load),
        .in_payload  (in_payload),
        .free        (to_free),
        .out_ready   (rx_to_ready),
        .out_valid   (rx_to_valid),
        .out_payload (to_payload)
    );

    rx_out_slot u_lr_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (lr_load),
        .in_payload  (in_payload),
        .free        (lr_free),
        .out_ready   (rx_lr_ready),
        .out_valid   (rx_lr_valid),
        .out_payload (lr_payload)
    );

    assign rx_to_sop    = to_payload[9];
    assign rx_to_eop    = to_payload[8];
    assign rx_to_data   = to_payload[7:0];
    assign rx_lr_sop    = lr_payload[9];
    assign rx_lr_eop    = lr_payload[8];
    assign rx_lr_data   = lr_payload[7:0];
    assign rx_data_on   = (state_q == ST_ROUTE_LR);
    assign rx_pid       = pid_q;
    assign rx_pid_err   = pid_err_q;
    assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_control_r.sv
// Bench for control_r: directed packets with hand-computed expectations plus a
// randomized run, all compared every cycle against a transaction-level model.
module tb_control_r;

    localparam bit CHECK_PID    = 1'b1;
    localparam bit DROP_SPECIAL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_lp_sop = 1'b0;
    logic       rx_lp_eop = 1'b0;
    logic       rx_lp_valid = 1'b0;
    logic       rx_lp_ready;
    logic [7:0] rx_lp_data = 8'h00;
    logic       rx_to_sop, rx_to_eop, rx_to_valid;
    logic       rx_to_ready = 1'b1;
    logic [7:0] rx_to_data;
    logic       rx_lr_sop, rx_lr_eop, rx_lr_valid;
    logic       rx_lr_ready = 1'b1;
    logic [7:0] rx_lr_data;
    logic       rx_data_on;
    logic [3:0] rx_pid;
    logic       rx_pid_err, rx_frame_err;

    int total = 0;
    int bad = 0;

    control_r dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_lp_sop    (rx_lp_sop),
        .rx_lp_eop    (rx_lp_eop),
        .rx_lp_valid  (rx_lp_valid),
        .rx_lp_ready  (rx_lp_ready),
        .rx_lp_data   (rx_lp_data),
        .rx_to_sop    (rx_to_sop),
        .rx_to_eop    (rx_to_eop),
        .rx_to_valid  (rx_to_valid),
        .rx_to_ready  (rx_to_ready),
        .rx_to_data   (rx_to_data),
        .rx_lr_sop    (rx_lr_sop),
        .rx_lr_eop    (rx_lr_eop),
        .rx_lr_valid  (rx_lr_valid),
        .rx_lr_ready  (rx_lr_ready),
        .rx_lr_data   (rx_lr_data),
        .rx_data_on   (rx_data_on),
        .rx_pid       (rx_pid),
        .rx_pid_err   (rx_pid_err),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    // Model of the router: where is the current packet going, and what sits in each output slot
    localparam int M_IDLE = 0;
    localparam int M_TO   = 1;
    localparam int M_LR   = 2;
    localparam int M_DROP = 3;

    int         mMode;
    logic [9:0] mToQ[$];
    logic [9:0] mLrQ[$];
    logic [9:0] mToLast;
    logic [9:0] mLrLast;
    logic [3:0] mPid;
    logic       mPidErr;
    logic       mFrameErr;

    // Bytes actually delivered downstream and pulse counts, for the directed checks
    logic [7:0] toLog[$];
    logic [7:0] lrLog[$];
    int         pidErrCnt = 0;
    int         frameErrCnt = 0;

    // Ready pattern control
    bit randRdy = 1'b0;
    int stallCycles = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic modelReady();
        logic toFree;
        logic lrFree;
        toFree = (mToQ.size() == 0) || rx_to_ready;
        lrFree = (mLrQ.size() == 0) || rx_lr_ready;
        case (mMode)
            M_IDLE:  return toFree && lrFree;
            M_TO:    return toFree;
            M_LR:    return lrFree;
            default: return 1'b1;
        endcase
    endfunction

    task automatic modelReset();
        mMode = M_IDLE;
        mToQ.delete();
        mLrQ.delete();
        mToLast = '0;
        mLrLast = '0;
        mPid = 4'h0;
        mPidErr = 1'b0;
        mFrameErr = 1'b0;
    endtask

    // Advance the model by one clock: decide the fate of the offered beat, then move the slots
    task automatic modelStep();
        logic       acc;
        logic       toFree;
        logic       lrFree;
        int         target;
        logic [9:0] beat;
        bit         pushTo;
        bit         pushLr;
        toFree = (mToQ.size() == 0) || rx_to_ready;
        lrFree = (mLrQ.size() == 0) || rx_lr_ready;
        acc = rx_lp_valid && modelReady();
        beat = {rx_lp_sop, rx_lp_eop, rx_lp_data};
        pushTo = 1'b0;
        pushLr = 1'b0;
        mPidErr = 1'b0;
        mFrameErr = 1'b0;
        if (acc) begin
            if (rx_lp_sop) begin
                mPid = rx_lp_data[3:0];
                mFrameErr = (mMode != M_IDLE);
                if (CHECK_PID && (rx_lp_data[3:0] != ~rx_lp_data[7:4])) begin
                    mPidErr = 1'b1;
                    target = M_DROP;
                end else if (rx_lp_data[1:0] == 2'b11) begin
                    target = M_LR;
                end else if (rx_lp_data[1:0] == 2'b00 && DROP_SPECIAL) begin
                    target = M_DROP;
                end else begin
                    target = M_TO;
                end
                if (target == M_TO && !toFree) target = M_DROP;
                if (target == M_LR && !lrFree) target = M_DROP;
                pushTo = (target == M_TO);
                pushLr = (target == M_LR);
                mMode = rx_lp_eop ? M_IDLE : target;
            end else begin
                if (mMode == M_IDLE) mFrameErr = 1'b1;
                pushTo = (mMode == M_TO);
                pushLr = (mMode == M_LR);
                if (rx_lp_eop) mMode = M_IDLE;
            end
        end
        if (mToQ.size() != 0 && rx_to_ready) void'(mToQ.pop_front());
        if (mLrQ.size() != 0 && rx_lr_ready) void'(mLrQ.pop_front());
        if (pushTo) begin
            mToQ.push_back(beat);
            mToLast = beat;
        end
        if (pushLr) begin
            mLrQ.push_back(beat);
            mLrLast = beat;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    // Compare every output against the model mid-cycle, and log what was delivered
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("lp_ready", rx_lp_ready, modelReady());
            checkOutput("to_valid", rx_to_valid, mToQ.size() != 0);
            checkOutput("to_beat", {rx_to_sop, rx_to_eop, rx_to_data}, mToLast);
            checkOutput("lr_valid", rx_lr_valid, mLrQ.size() != 0);
            checkOutput("lr_beat", {rx_lr_sop, rx_lr_eop, rx_lr_data}, mLrLast);
            checkOutput("data_on", rx_data_on, mMode == M_LR);
            checkOutput("pid", rx_pid, mPid);
            checkOutput("pid_err", rx_pid_err, mPidErr);
            checkOutput("frame_err", rx_frame_err, mFrameErr);
            if (rx_to_valid && rx_to_ready) toLog.push_back(rx_to_data);
            if (rx_lr_valid && rx_lr_ready) lrLog.push_back(rx_lr_data);
            if (rx_pid_err) pidErrCnt++;
            if (rx_frame_err) frameErrCnt++;
        end
    end

    // Downstream ready driver: always ready, random, or a forced link-layer stall window
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stallCycles > 0) begin
                rx_to_ready = 1'b1;
                rx_lr_ready = 1'b0;
                stallCycles--;
            end else if (randRdy) begin
                rx_to_ready = ($urandom_range(99) < 75);
                rx_lr_ready = ($urandom_range(99) < 75);
            end else begin
                rx_to_ready = 1'b1;
                rx_lr_ready = 1'b1;
            end
        end
    end

    // Offer one beat until it is accepted (valid may be randomly withheld)
    task automatic applyStimulus(input logic s, input logic e, input logic [7:0] d, input int validPct);
        bit done;
        bit acc;
        int guard;
        done = 1'b0;
        guard = 0;
        while (!done) begin
            rx_lp_valid = ($urandom_range(99) < validPct);
            rx_lp_sop = s;
            rx_lp_eop = e;
            rx_lp_data = d;
            @(negedge clk);
            acc = rx_lp_valid && rx_lp_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                done = 1'b1;
            end else if (guard > 300) begin
                checkOutput("beat_accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        rx_lp_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        toLog.delete();
        lrLog.delete();
        pidErrCnt = 0;
        frameErrCnt = 0;
    endtask

    logic [3:0] pidTab[12];
    logic [7:0] expBytes[$];
    logic [7:0] first;
    logic [3:0] pidv;
    int         kind;
    int         len;
    bit         abort;

    initial begin
        pidTab = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h7, 4'hF, 4'h2, 4'hA, 4'hE, 4'hC};
        rst_n = 1'b0;
        idleCycles(3);
        checkOutput("reset_to_valid", rx_to_valid, 1'b0);
        checkOutput("reset_lr_valid", rx_lr_valid, 1'b0);
        checkOutput("reset_pid", rx_pid, 4'h0);
        rst_n = 1'b1;
        idleCycles(2);

        // Token OUT to the crc5 path
        clearLogs();
        applyStimulus(1'b1, 1'b0, 8'hE1, 100);
        applyStimulus(1'b0, 1'b0, 8'h15, 100);
        applyStimulus(1'b0, 1'b1, 8'h07, 100);
        idleCycles(3);
        checkOutput("t1_to_count", toLog.size(), 3);
        checkOutput("t1_lr_count", lrLog.size(), 0);
        if (toLog.size() == 3) begin
            checkOutput("t1_byte0", toLog[0], 8'hE1);
            checkOutput("t1_byte2", toLog[2], 8'h07);
        end
        checkOutput("t1_pid", rx_pid, 4'h1);

        // DATA0 to the link layer
        clearLogs();
        applyStimulus(1'b1, 1'b0, 8'hC3, 100);
        checkOutput("t2_data_on", rx_data_on, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h01, 100);
        applyStimulus(1'b0, 1'b0, 8'h02, 100);
        applyStimulus(1'b0, 1'b0, 8'h3F, 100);
        applyStimulus(1'b0, 1'b1, 8'h8A, 100);
        idleCycles(3);
        checkOutput("t2_data_off", rx_data_on, 1'b0);
        expBytes = '{8'hC3, 8'h01, 8'h02, 8'h3F, 8'h8A};
        checkOutput("t2_lr_count", lrLog.size(), 5);
        for (int i = 0; i < 5 && i < lrLog.size(); i++) checkOutput("t2_lr_byte", lrLog[i], expBytes[i]);
        checkOutput("t2_to_count", toLog.size(), 0);
        checkOutput("t2_pid", rx_pid, 4'h3);

        // Bad PID is dropped with one error pulse
        clearLogs();
        applyStimulus(1'b1, 1'b0, 8'hC4, 100);
        applyStimulus(1'b0, 1'b1, 8'h11, 100);
        idleCycles(3);
        checkOutput("t3_delivered", toLog.size() + lrLog.size(), 0);
        checkOutput("t3_pid_err_cnt", pidErrCnt, 1);
        checkOutput("t3_frame_err_cnt", frameErrCnt, 0);

        // DATA1 with a link-layer stall mid-packet
        clearLogs();
        applyStimulus(1'b1, 1'b0, 8'h4B, 100);
        applyStimulus(1'b0, 1'b0, 8'h10, 100);
        stallCycles = 3;
        applyStimulus(1'b0, 1'b0, 8'h20, 100);
        applyStimulus(1'b0, 1'b0, 8'h30, 100);
        applyStimulus(1'b0, 1'b0, 8'h40, 100);
        applyStimulus(1'b0, 1'b1, 8'h5E, 100);
        idleCycles(4);
        expBytes = '{8'h4B, 8'h10, 8'h20, 8'h30, 8'h40, 8'h5E};
        checkOutput("t4_lr_count", lrLog.size(), 6);
        for (int i = 0; i < 6 && i < lrLog.size(); i++) checkOutput("t4_lr_byte", lrLog[i], expBytes[i]);

        // Single-beat ACK followed at once by DATA1
        clearLogs();
        applyStimulus(1'b1, 1'b1, 8'hD2, 100);
        applyStimulus(1'b1, 1'b0, 8'h4B, 100);
        applyStimulus(1'b0, 1'b1, 8'h99, 100);
        idleCycles(3);
        checkOutput("t5_to_count", toLog.size(), 1);
        if (toLog.size() == 1) checkOutput("t5_to_byte", toLog[0], 8'hD2);
        checkOutput("t5_lr_count", lrLog.size(), 2);
        if (lrLog.size() == 2) checkOutput("t5_lr_byte", lrLog[0], 8'h4B);
        checkOutput("t5_err_cnt", pidErrCnt + frameErrCnt, 0);

        // Stray byte, reset mid-packet, recovery, then a dropped PRE
        clearLogs();
        applyStimulus(1'b0, 1'b0, 8'h55, 100);
        idleCycles(2);
        checkOutput("t6_frame_err_cnt", frameErrCnt, 1);
        applyStimulus(1'b1, 1'b0, 8'hC3, 100);
        applyStimulus(1'b0, 1'b0, 8'h01, 100);
        rst_n = 1'b0;
        #2;
        checkOutput("t6_rst_lr_valid", rx_lr_valid, 1'b0);
        checkOutput("t6_rst_to_valid", rx_to_valid, 1'b0);
        checkOutput("t6_rst_data_on", rx_data_on, 1'b0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);
        clearLogs();
        applyStimulus(1'b1, 1'b0, 8'hE1, 100);
        applyStimulus(1'b0, 1'b1, 8'h42, 100);
        idleCycles(3);
        checkOutput("t6_token_count", toLog.size(), 2);
        if (toLog.size() == 2) checkOutput("t6_token_byte", toLog[0], 8'hE1);
        clearLogs();
        applyStimulus(1'b1, 1'b1, 8'h3C, 100);
        idleCycles(3);
        checkOutput("t6_pre_delivered", toLog.size() + lrLog.size(), 0);
        checkOutput("t6_pre_errs", pidErrCnt + frameErrCnt, 0);
        checkOutput("t6_pre_pid", rx_pid, 4'hC);

        // Randomized traffic with random backpressure, checked by the model each cycle
        randRdy = 1'b1;
        for (int p = 0; p < 150; p++) begin
            kind = $urandom_range(9);
            if (kind == 0) begin
                applyStimulus(1'b0, 1'($urandom_range(1)), 8'($urandom), 80);
            end else begin
                if (kind == 1) begin
                    first = 8'($urandom);
                end else begin
                    pidv = pidTab[$urandom_range(11)];
                    first = {~pidv, pidv};
                end
                len = $urandom_range(1, 5);
                abort = ($urandom_range(9) == 0);
                for (int i = 0; i < len; i++) begin
                    applyStimulus(i == 0, (i == len - 1) && !abort, (i == 0) ? first : 8'($urandom), 80);
                end
            end
        end
        randRdy = 1'b0;
        idleCycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
